// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Load/store op encodings shared between the core control path and the
//   memory responder, plus helpers that turn an op into a byte count.
//   Ports: none (package).
package mem_responder_pkg;

  // Load op encodings (read_op)
  localparam logic [2:0] LB    = 3'b000;
  localparam logic [2:0] LH    = 3'b001;
  localparam logic [2:0] LW    = 3'b010;
  localparam logic [2:0] LNONE = 3'b011;
  localparam logic [2:0] LBU   = 3'b100;
  localparam logic [2:0] LHU   = 3'b101;

  // Store op encodings (write_op)
  localparam logic [1:0] SB    = 2'b00;
  localparam logic [1:0] SH    = 2'b01;
  localparam logic [1:0] SW    = 2'b10;
  localparam logic [1:0] SNONE = 2'b11;

  // 3'b110, 3'b111 and LNONE are not loads.
  function automatic logic load_valid(input logic [2:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  // Index of the final byte slot of a load (byte count minus one).
  function automatic logic [1:0] load_last(input logic [2:0] op);
    case (op)
      LH, LHU: return 2'd1;
      LW:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Index of the final byte slot of a store (byte count minus one).
  function automatic logic [1:0] store_last(input logic [1:0] op);
    case (op)
      SH:      return 2'd1;
      SW:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_extend.sv
// mem_extend
//   Combinational sign/zero extension of an assembled little-endian load.
//   Ports:
//     op     in  3   load op (LB/LH/LW/LBU/LHU)
//     raw    in  32  assembled bytes, byte 0 in [7:0]
//     result out 32  extended load value
module mem_extend
  import mem_responder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (op)
      LB:      result = {{24{raw[7]}}, raw[7:0]};
      LBU:     result = {24'h000000, raw[7:0]};
      LH:      result = {{16{raw[15]}}, raw[15:0]};
      LHU:     result = {16'h0000, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Serves core load/store requests from an 8-bit SRAM, one byte per slot
//   of WAIT+1 cycles. Reads are assembled little-endian and extended;
//   misaligned halfword/word requests are rejected without touching SRAM.
//   Ports:
//     clk, reset_n             clock, asynchronous active-low reset
//     addr, read_op, write_op  request (write wins if both present)
//     write_data               store data, LSB-aligned
//     read_data                extended load result, held until next load
//     busy, done, misaligned   handshake; misaligned qualifies done
//     sram_*                   external byte-wide SRAM interface
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        read_op,
  input  logic [1:0]        write_op,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sram_ce,
  output logic              sram_we
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic              is_write_reg, is_write_next;
  logic [2:0]        rop_reg, rop_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [1:0]        last_reg, last_next;
  logic [1:0]        idx_reg, idx_next;
  logic [2:0]        wait_reg, wait_next;
  logic [31:0]       lanes_reg, lanes_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              mis_reg, mis_next;

  logic              wr_req, rd_req;
  logic [1:0]        req_last;
  logic              req_mis;
  logic [31:0]       lanes_merged;
  logic [31:0]       extended;

  assign wr_req   = (write_op != SNONE);
  assign rd_req   = load_valid(read_op);
  assign req_last = wr_req ? store_last(write_op) : load_last(read_op);
  assign req_mis  = ((req_last == 2'd1) && addr[0]) ||
                    ((req_last == 2'd3) && (addr[1:0] != 2'b00));

  // The last byte of a read arrives in the same cycle the FSM leaves
  // ACCESS, so the extender sees the lanes with the live SRAM byte merged in.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes_merged[gi*8 +: 8] = (idx_reg == 2'(gi)) ? sram_rdata
                                                            : lanes_reg[gi*8 +: 8];
    end
  endgenerate

  mem_extend u_extend (
    .op     (rop_reg),
    .raw    (lanes_merged),
    .result (extended)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      is_write_reg <= 1'b0;
      rop_reg      <= LNONE;
      wdata_reg    <= '0;
      last_reg     <= '0;
      idx_reg      <= '0;
      wait_reg     <= '0;
      lanes_reg    <= '0;
      rdata_reg    <= '0;
      mis_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      is_write_reg <= is_write_next;
      rop_reg      <= rop_next;
      wdata_reg    <= wdata_next;
      last_reg     <= last_next;
      idx_reg      <= idx_next;
      wait_reg     <= wait_next;
      lanes_reg    <= lanes_next;
      rdata_reg    <= rdata_next;
      mis_reg      <= mis_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    is_write_next = is_write_reg;
    rop_next      = rop_reg;
    wdata_next    = wdata_reg;
    last_next     = last_reg;
    idx_next      = idx_reg;
    wait_next     = wait_reg;
    lanes_next    = lanes_reg;
    rdata_next    = rdata_reg;
    mis_next      = mis_reg;
    busy          = 1'b0;
    done          = 1'b0;
    misaligned    = 1'b0;
    sram_ce       = 1'b0;
    sram_we       = 1'b0;
    sram_addr     = '0;
    sram_wdata    = '0;

    case (state_reg)
      IDLE: begin
        if (wr_req || rd_req) begin
          base_next     = addr;
          is_write_next = wr_req;
          rop_next      = read_op;
          wdata_next    = write_data;
          last_next     = req_last;
          idx_next      = 2'd0;
          wait_next     = 3'd0;
          mis_next      = req_mis;
          state_next    = req_mis ? DONE : ACCESS;
        end
      end

      ACCESS: begin
        busy      = 1'b1;
        sram_ce   = 1'b1;
        sram_addr = base_reg + {{(ADDR_W-2){1'b0}}, idx_reg};
        sram_we   = is_write_reg;
        if (is_write_reg) begin
          sram_wdata = wdata_reg[{idx_reg, 3'b000} +: 8];
        end
        if (wait_reg == WAIT_LAST) begin
          wait_next = 3'd0;
          if (!is_write_reg) begin
            lanes_next = lanes_merged;
          end
          if (idx_reg == last_reg) begin
            state_next = DONE;
            if (!is_write_reg) begin
              rdata_next = extended;
            end
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end else begin
          wait_next = wait_reg + 3'd1;
        end
      end

      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        misaligned = mis_reg;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign read_data = rdata_reg;

endmodule
